// File: rtl/cond_pkg.sv
// Shared types for the qualified-condition detector: reduction modes and FSM states.
package cond_pkg;

  typedef enum logic [1:0] {
    MODE_AND = 2'b00,
    MODE_OR  = 2'b01,
    MODE_XOR = 2'b10,
    MODE_NOR = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    QUAL   = 2'b01,
    ACTIVE = 2'b10
  } state_t;

endpackage

// File: rtl/cond_reduce.sv
// Combinational N-input reduction selected by mode (AND/OR/XOR/NOR).
// Zero latency, no flow control.
module cond_reduce
  import cond_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [1:0]   mode,
  input  logic [N-1:0] in_vec,
  output logic         c
);

  always_comb begin
    c = 1'b0;
    case (mode)
      MODE_AND: c = &in_vec;
      MODE_OR:  c = |in_vec;
      MODE_XOR: c = ^in_vec;
      MODE_NOR: c = ~|in_vec;
    endcase
  end

endmodule

// File: rtl/cond_qual_detector.sv
// Glitch-qualified condition flag: y asserts on the edge sampling the HOLD-th consecutive true
// reduction, drops on the first false sample; registered rise/fall pulses and a saturating rise count.
module cond_qual_detector
  import cond_pkg::*;
#(
  parameter int N     = 4,
  parameter int HOLD  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     in_vec,
  input  logic             clr_cnt,
  output logic             y,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] event_cnt
);

  localparam int RUN_W = $clog2(HOLD + 1);
  localparam logic [RUN_W-1:0] HOLD_R = RUN_W'(HOLD);

  logic             c;
  state_t           state, state_nxt;
  logic [RUN_W-1:0] run, run_nxt, run_inc;
  logic             y_nxt, rise_nxt, fall_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  cond_reduce #(.N(N)) u_reduce (
    .mode   (mode),
    .in_vec (in_vec),
    .c      (c)
  );

  // run is zero in IDLE, so IDLE and QUAL share the same advance rule.
  assign run_inc = (run == HOLD_R) ? run : run + 1'b1;

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    y_nxt     = 1'b0;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      run_nxt   = '0;
      fall_nxt  = y;
    end else begin
      case (state)
        IDLE, QUAL: begin
          if (c) begin
            run_nxt = run_inc;
            if (run_inc == HOLD_R) begin
              state_nxt = ACTIVE;
              y_nxt     = 1'b1;
              rise_nxt  = 1'b1;
            end else begin
              state_nxt = QUAL;
            end
          end else begin
            state_nxt = IDLE;
            run_nxt   = '0;
          end
        end
        ACTIVE: begin
          if (c) begin
            run_nxt = run_inc;
            y_nxt   = 1'b1;
          end else begin
            state_nxt = IDLE;
            run_nxt   = '0;
            fall_nxt  = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          run_nxt   = '0;
        end
      endcase
    end
  end

  // Clear wins over a coincident rise; the count sticks at all-ones.
  always_comb begin
    cnt_nxt = event_cnt;
    if (clr_cnt)
      cnt_nxt = '0;
    else if (rise_nxt && (event_cnt != {CNT_W{1'b1}}))
      cnt_nxt = event_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      run       <= '0;
      y         <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      event_cnt <= '0;
    end else begin
      state     <= state_nxt;
      run       <= run_nxt;
      y         <= y_nxt;
      rise      <= rise_nxt;
      fall      <= fall_nxt;
      event_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_cond_qual_detector.sv
// Three detector instances (HOLD=3, HOLD=1, 2-bit counter) driven in lockstep against a streak-count model.
module tb_cond_qual_detector;

  logic       clk = 1'b0;
  logic       rst_n, en, clr_cnt;
  logic [1:0] mode;
  logic [3:0] in_vec;

  logic       y0, r0, f0, y1, r1, f1, y2, r2, f2;
  logic [7:0] ec0, ec1;
  logic [1:0] ec2;

  int checks = 0;
  int errors = 0;

  int streak [0:2];
  bit my [0:2];
  bit mr [0:2];
  bit mf [0:2];
  int mc [0:2];
  int hold [0:2] = '{3, 1, 3};
  int cmax [0:2] = '{255, 255, 3};

  always #5 clk = ~clk;

  cond_qual_detector #(.N(4), .HOLD(3), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_vec(in_vec), .clr_cnt(clr_cnt),
    .y(y0), .rise(r0), .fall(f0), .event_cnt(ec0));
  cond_qual_detector #(.N(4), .HOLD(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_vec(in_vec), .clr_cnt(clr_cnt),
    .y(y1), .rise(r1), .fall(f1), .event_cnt(ec1));
  cond_qual_detector #(.N(4), .HOLD(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_vec(in_vec), .clr_cnt(clr_cnt),
    .y(y2), .rise(r2), .fall(f2), .event_cnt(ec2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit ref_c(input logic [1:0] m, input logic [3:0] v);
    int ones = 0;
    for (int b = 0; b < 4; b++) if (v[b]) ones++;
    case (m)
      2'b00:   return ones == 4;
      2'b01:   return ones > 0;
      2'b10:   return (ones % 2) == 1;
      default: return ones == 0;
    endcase
  endfunction

  task automatic model_update();
    bit cv, yn;
    cv = ref_c(mode, in_vec);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        streak[i] = 0; my[i] = 0; mr[i] = 0; mf[i] = 0; mc[i] = 0;
      end else begin
        if (en && cv) streak[i] = (streak[i] < 1000) ? streak[i] + 1 : streak[i];
        else          streak[i] = 0;
        yn    = en && (streak[i] >= hold[i]);
        mr[i] = yn && !my[i];
        mf[i] = !yn && my[i];
        my[i] = yn;
        if (clr_cnt)                        mc[i] = 0;
        else if (mr[i] && mc[i] < cmax[i])  mc[i] = mc[i] + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("y0", y0, my[0]);  check("rise0", r0, mr[0]);
    check("fall0", f0, mf[0]); check("cnt0", ec0, mc[0]);
    check("y1", y1, my[1]);  check("rise1", r1, mr[1]);
    check("fall1", f1, mf[1]); check("cnt1", ec1, mc[1]);
    check("y2", y2, my[2]);  check("rise2", r2, mr[2]);
    check("fall2", f2, mf[2]); check("cnt2", ec2, mc[2]);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_update();
      #1;
      compare_all();
    end
  endtask

  task automatic drive(input logic [3:0] v, input int n);
    in_vec = v;
    cyc(n);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clr_cnt = 1'b0; mode = 2'b00; in_vec = 4'b0000;
    cyc(2);
    check("rst_y", y0, 0); check("rst_cnt", ec0, 0);
    rst_n = 1'b1;

    // basic qualification
    drive(4'b1111, 2);
    check("pre_hold_y", y0, 0);
    drive(4'b1111, 1);
    check("hold_rise", r0, 1); check("hold_cnt", ec0, 1);
    drive(4'b1111, 2);
    check("rise_once", r0, 0);

    // glitch reject
    drive(4'b0000, 1);
    drive(4'b1111, 2); drive(4'b1110, 1); drive(4'b1111, 3);

    // release and other modes
    drive(4'b0111, 1);
    check("release_fall", f0, 1);
    mode = 2'b10; drive(4'b0111, 3);
    check("xor_y", y0, 1);
    mode = 2'b11; drive(4'b0000, 3);
    check("nor_y", y0, 1);

    // HOLD=1 alternation
    mode = 2'b00;
    for (int k = 0; k < 8; k++) drive((k % 2) ? 4'b0000 : 4'b1111, 1);

    // en drop while active
    drive(4'b1111, 4);
    en = 1'b0; cyc(1);
    check("en_fall", f0, 1);
    en = 1'b1;

    // reset mid-qualification
    drive(4'b0000, 1);
    drive(4'b1111, 2);
    rst_n = 1'b0; cyc(1);
    check("rst_no_fall", f0, 0);
    rst_n = 1'b1;
    drive(4'b1111, 2);
    check("requal_y", y0, 0);
    drive(4'b1111, 2);

    // counter saturation and clear priority
    for (int k = 0; k < 5; k++) begin drive(4'b0000, 1); drive(4'b1111, 3); end
    check("sat_cnt", ec2, 3);
    drive(4'b0000, 1); drive(4'b1111, 2);
    clr_cnt = 1'b1; cyc(1);
    check("clr_rise_pulse", r2, 1); check("clr_rise_cnt", ec2, 0);
    clr_cnt = 1'b0;

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: in_vec = 4'b1111;
          1: in_vec = 4'b0000;
          2: in_vec = 4'b0111;
          default: in_vec = 4'($urandom);
        endcase
      end
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom);
      en      = ($urandom_range(0, 19) != 0);
      clr_cnt = ($urandom_range(0, 63) == 0);
      rst_n   = ($urandom_range(0, 199) != 0);
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
